// File: rtl/elgamal_pkg.sv
// Shared types and constants for the ElGamal decryption engine.
package elgamal_pkg;

  localparam int SIZE_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXP   = 2'd1,
    S_FINAL = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Accept edge to m_tvalid rising: one setup cycle, SIZE exponent rounds,
  // one final multiply, each multiply SIZE+1 cycles.
  function automatic int lat(input int size);
    return (size + 1) * (size + 1) + 1;
  endfunction

endpackage

// File: rtl/elgamal_decrypt_mod_mul_interleaved.sv
// Interleaved MSB-first modular multiplier: result = a*b mod p, requires a < p.
// Start sampled in cycle 0, done pulses in cycle SIZE with the result valid combinationally.
module mod_mul_interleaved
  import elgamal_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  input  logic [SIZE-1:0] i_p,
  output logic            o_done,
  output logic [SIZE-1:0] o_res
);

  localparam int IW = $clog2(SIZE);

  logic            r_busy;
  logic [IW-1:0]   r_idx;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [SIZE-1:0] r_p;
  logic [SIZE-1:0] r_acc;
  logic [SIZE-1:0] w_step;

  // One iteration: double, reduce, conditionally add a, reduce; SIZE+1 bits is enough.
  function automatic logic [SIZE-1:0] mm_step(input logic [SIZE-1:0] acc,
                                              input logic [SIZE-1:0] a,
                                              input logic [SIZE-1:0] p,
                                              input logic            b_bit);
    logic [SIZE:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, p}) t = t - {1'b0, p};
    if (b_bit) t = t + {1'b0, a};
    if (t >= {1'b0, p}) t = t - {1'b0, p};
    return t[SIZE-1:0];
  endfunction

  assign w_step = mm_step(r_acc, r_a, r_p, r_b[r_idx]);
  // Bit 0 is folded in combinationally so the product is ready in the done cycle.
  assign o_done = r_busy && (r_idx == '0);
  assign o_res  = w_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_idx  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_acc  <= '0;
    end else if (i_start && !r_busy) begin
      r_busy <= 1'b1;
      r_idx  <= IW'(SIZE - 1);
      r_a    <= i_a;
      r_b    <= i_b;
      r_p    <= i_p;
      r_acc  <= '0;
    end else if (r_busy) begin
      r_acc <= w_step;
      if (r_idx == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_idx <= r_idx - IW'(1);
      end
    end
  end

endmodule

// File: rtl/elgamal_decrypt.sv
// ElGamal decryption m = c2 * c1^(p-1-x) mod p, constant-time LSB-first square-and-multiply.
// Fixed latency lat(SIZE) from accept to m_tvalid; m_tready low holds the result in OUT.
module elgamal_decrypt
  import elgamal_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] s_c1_tdata,
  input  logic [SIZE-1:0] s_c2_tdata,
  input  logic            s_tvalid,
  output logic            s_tready,
  input  logic [SIZE-1:0] key_x,
  input  logic [SIZE-1:0] key_p,
  output logic [SIZE-1:0] m_tdata,
  output logic            m_tuser,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            busy
);

  localparam int KW = $clog2(SIZE);

  state_t          r_state;
  state_t          w_state_nxt;

  logic [SIZE-1:0] r_c1;
  logic [SIZE-1:0] r_c2;
  logic [SIZE-1:0] r_p;
  logic [SIZE-1:0] r_x;
  logic [SIZE-1:0] r_e;
  logic [SIZE-1:0] r_res;
  logic [SIZE-1:0] r_base;
  logic [SIZE-1:0] r_m_tdata;
  logic            r_m_tuser;
  logic            r_err;
  logic            r_first;
  logic            r_start;
  logic [KW-1:0]   r_k;

  logic            w_accept;
  logic            w_err;
  logic            w_last_round;
  logic            w_rnd_done;
  logic            w_done_a;
  logic            w_done_b;
  logic            w_start_b;
  logic [SIZE-1:0] w_b_a;
  logic [SIZE-1:0] w_prod_a;
  logic [SIZE-1:0] w_prod_b;

  assign s_tready     = (r_state == S_IDLE) && !rst;
  assign m_tvalid     = (r_state == S_OUT);
  assign busy         = (r_state != S_IDLE);
  assign m_tdata      = r_m_tdata;
  assign m_tuser      = r_m_tuser;

  assign w_accept     = s_tvalid && s_tready;
  assign w_last_round = (r_k == KW'(SIZE - 1));
  assign w_rnd_done   = w_done_a && w_done_b;

  // Evaluated on the registered job in the setup cycle; p<3 is tested first so p-1 cannot wrap.
  assign w_err = (r_p < SIZE'(3)) || (r_x == '0) || (r_x >= r_p - SIZE'(1)) ||
                 (r_c1 == '0) || (r_c1 >= r_p) || (r_c2 >= r_p);

  // Multiplier A is the running product in EXP and c2*res in FINAL; B squares the base.
  assign w_b_a     = (r_state == S_FINAL) ? r_c2 : r_base;
  assign w_start_b = r_start && (r_state == S_EXP);

  mod_mul_interleaved #(.SIZE(SIZE)) u_mul_a (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_start),
    .i_a     (r_res),
    .i_b     (w_b_a),
    .i_p     (r_p),
    .o_done  (w_done_a),
    .o_res   (w_prod_a)
  );

  mod_mul_interleaved #(.SIZE(SIZE)) u_mul_b (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start_b),
    .i_a     (r_base),
    .i_b     (r_base),
    .i_p     (r_p),
    .o_done  (w_done_b),
    .o_res   (w_prod_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (s_tvalid) w_state_nxt = S_EXP;
      S_EXP:   if (w_rnd_done && w_last_round) w_state_nxt = S_FINAL;
      S_FINAL: if (w_done_a) w_state_nxt = S_OUT;
      S_OUT:   if (m_tready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c1      <= '0;
      r_c2      <= '0;
      r_p       <= '0;
      r_x       <= '0;
      r_e       <= '0;
      r_res     <= '0;
      r_base    <= '0;
      r_m_tdata <= '0;
      r_m_tuser <= 1'b0;
      r_err     <= 1'b0;
      r_first   <= 1'b0;
      r_start   <= 1'b0;
      r_k       <= '0;
    end else begin
      r_first <= 1'b0;
      // A fresh multiply starts after the setup cycle and after every round update.
      r_start <= (r_state == S_EXP) && (r_first || w_rnd_done);

      if (w_accept) begin
        r_c1    <= s_c1_tdata;
        r_c2    <= s_c2_tdata;
        r_p     <= key_p;
        r_x     <= key_x;
        r_k     <= '0;
        r_first <= 1'b1;
      end

      if (r_first) begin
        r_e    <= r_p - r_x - SIZE'(1);
        r_err  <= w_err;
        r_base <= w_err ? SIZE'(1) : r_c1;
        r_res  <= SIZE'(1);
      end

      if ((r_state == S_EXP) && w_rnd_done) begin
        if (r_e[r_k]) r_res <= w_prod_a;
        r_base <= w_prod_b;
        r_k    <= w_last_round ? '0 : r_k + KW'(1);
      end

      if ((r_state == S_FINAL) && w_done_a) begin
        r_m_tdata <= r_err ? '0 : w_prod_a;
        r_m_tuser <= r_err;
      end
    end
  end

`ifndef SYNTHESIS
  int r_cyc;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_cyc <= 0;
    end else if (busy) begin
      r_cyc <= r_cyc + 1;
    end
    if (!rst && (r_state == S_FINAL) && w_done_a) begin
      assert (r_cyc + 1 == lat(SIZE));
    end
  end
`endif

endmodule

// File: tb/tb_elgamal_decrypt.sv
// Directed bench for elgamal_decrypt at SIZE=8 with hand-computed vectors and corner sequences.
module tb_elgamal_decrypt;

  localparam int W   = 8;
  localparam int LAT = 82;
  localparam int NV  = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] s_c1;
  logic [W-1:0] s_c2;
  logic         s_tvalid;
  logic         s_tready;
  logic [W-1:0] key_x;
  logic [W-1:0] key_p;
  logic [W-1:0] m_tdata;
  logic         m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] x;
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    logic [W-1:0] m;
    logic         err;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  elgamal_decrypt #(.SIZE(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_c1_tdata (s_c1),
    .s_c2_tdata (s_c2),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .key_x      (key_x),
    .key_p      (key_p),
    .m_tdata    (m_tdata),
    .m_tuser    (m_tuser),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a job and returns just after the accepting edge with keys/data scrambled.
  task automatic accept_job(input logic [W-1:0] p, input logic [W-1:0] x,
                            input logic [W-1:0] c1, input logic [W-1:0] c2);
    int n;
    key_p = p; key_x = x; s_c1 = c1; s_c2 = c2; s_tvalid = 1'b1;
    n = 0;
    while (!s_tready && n < 100) begin
      tick();
      n++;
    end
    chk("accept_rdy", s_tready, 1);
    tick();
    s_tvalid = 1'b0;
    key_p = W'($urandom);
    key_x = W'($urandom);
    s_c1  = W'($urandom);
    s_c2  = W'($urandom);
  endtask

  task automatic wait_out(output logic [W-1:0] d, output logic u, output int lat);
    lat = 0;
    while (!m_tvalid && lat < 300) begin
      tick();
      lat++;
    end
    d = m_tdata;
    u = m_tuser;
  endtask

  task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] x,
                         input logic [W-1:0] c1, input logic [W-1:0] c2,
                         output logic [W-1:0] d, output logic u, output int lat);
    accept_job(p, x, c1, c2);
    wait_out(d, u, lat);
  endtask

  initial begin
    logic [W-1:0] d;
    logic         u;
    int           lat;
    int           cnt;
    int           e;
    int           h;
    int           a2;
    logic [W-1:0] d1;

    //            p        x        c1       c2       m        err
    vecs[0]  = '{8'd23,  8'd6,   8'd10,  8'd14,  8'd10,  1'b0};
    vecs[1]  = '{8'd23,  8'd1,   8'd2,   8'd2,   8'd1,   1'b0};
    vecs[2]  = '{8'd23,  8'd6,   8'd0,   8'd14,  8'd0,   1'b1};
    vecs[3]  = '{8'd23,  8'd6,   8'd10,  8'd23,  8'd0,   1'b1};
    vecs[4]  = '{8'd23,  8'd22,  8'd10,  8'd14,  8'd0,   1'b1};
    vecs[5]  = '{8'd2,   8'd1,   8'd1,   8'd1,   8'd0,   1'b1};
    vecs[6]  = '{8'd23,  8'd0,   8'd5,   8'd5,   8'd0,   1'b1};
    vecs[7]  = '{8'd23,  8'd6,   8'd23,  8'd14,  8'd0,   1'b1};
    vecs[8]  = '{8'd11,  8'd3,   8'd2,   8'd5,   8'd2,   1'b0};
    vecs[9]  = '{8'd251, 8'd249, 8'd3,   8'd7,   8'd21,  1'b0};
    vecs[10] = '{8'd23,  8'd21,  8'd5,   8'd1,   8'd5,   1'b0};
    vecs[11] = '{8'd23,  8'd6,   8'd10,  8'd0,   8'd0,   1'b0};
    vecs[12] = '{8'd3,   8'd1,   8'd2,   8'd1,   8'd2,   1'b0};
    vecs[13] = '{8'd13,  8'd2,   8'd6,   8'd9,   8'd10,  1'b0};

    rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
    s_c1 = '0; s_c2 = '0; key_x = '0; key_p = '0;
    repeat (3) tick();
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tuser", m_tuser, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_s_tready", s_tready, 1);

    for (int i = 0; i < NV; i++) begin
      run_job(vecs[i].p, vecs[i].x, vecs[i].c1, vecs[i].c2, d, u, lat);
      chk($sformatf("v%0d_latency", i), lat, LAT);
      chk($sformatf("v%0d_m_tdata", i), d, vecs[i].m);
      chk($sformatf("v%0d_m_tuser", i), u, vecs[i].err);
      tick();
      chk($sformatf("v%0d_idle_rdy", i), s_tready, 1);
    end

    // Backpressure: result held for 10 stalled cycles, no new accept until after handshake.
    m_tready = 1'b0;
    run_job(8'd23, 8'd6, 8'd10, 8'd14, d, u, lat);
    chk("bp_latency", lat, LAT);
    s_tvalid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (m_tvalid && m_tdata == 8'd10 && !m_tuser && !s_tready && busy) cnt++;
    end
    chk("bp_stable_cycles", cnt, 10);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    chk("bp_rdy_before_hs", s_tready, 0);
    tick();
    chk("bp_rdy_after_hs", s_tready, 1);
    chk("bp_valid_after_hs", m_tvalid, 0);

    // Reset in the middle of a job.
    accept_job(8'd23, 8'd6, 8'd10, 8'd14);
    repeat (39) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_s_tready", s_tready, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("mid_post_rdy", s_tready, 1);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (m_tvalid) cnt++;
    end
    chk("mid_no_output", cnt, 0);
    run_job(8'd23, 8'd6, 8'd10, 8'd14, d, u, lat);
    chk("mid_next_data", d, 10);
    chk("mid_next_lat", lat, LAT);
    tick();

    // Back-to-back: second job waits on s_tvalid and is taken one cycle after the handshake.
    accept_job(8'd23, 8'd6, 8'd10, 8'd14);
    key_p = 8'd11; key_x = 8'd3; s_c1 = 8'd2; s_c2 = 8'd5; s_tvalid = 1'b1;
    e = 0; h = -1; a2 = -1; d1 = '0;
    while (a2 < 0 && e < 400) begin
      if (m_tvalid && m_tready && h < 0) begin
        h  = e + 1;
        d1 = m_tdata;
      end
      if (s_tvalid && s_tready) a2 = e + 1;
      if (a2 < 0) begin
        tick();
        e++;
      end
    end
    chk("b2b_first_data", d1, 10);
    chk("b2b_hs_edge", h, LAT + 1);
    chk("b2b_accept_edge", a2, LAT + 2);
    tick();
    s_tvalid = 1'b0;
    wait_out(d, u, lat);
    chk("b2b_second_data", d, 2);
    chk("b2b_second_lat", lat, LAT);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
